// File: rtl/branch_predictor_ras_pkg.sv
// Shared encodings and helpers for the fetch-stage BTB + return-address-stack predictor.
package branch_predictor_ras_pkg;

  typedef enum logic [1:0] {
    KIND_COND = 2'b00,
    KIND_JUMP = 2'b01,
    KIND_RET  = 2'b10
  } kind_e;

  localparam logic [1:0] CTR_WEAK_T = 2'b10;
  localparam logic [1:0] CTR_RESET  = 2'b01;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/branch_predictor_ras_if.sv
// Lookup and resolution-update bundle between fetch/ID and the predictor.
interface branch_predictor_ras_if #(parameter int XLEN = 32);
  logic            enable;
  logic [XLEN-1:0] fetch_pc;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            upd_valid;
  logic [XLEN-1:0] upd_pc;
  logic [XLEN-1:0] upd_target;
  logic            upd_taken;
  logic [1:0]      upd_kind;
  logic            upd_call;

  modport master (
    output enable, fetch_pc, upd_valid, upd_pc, upd_target, upd_taken, upd_kind, upd_call,
    input  pred_taken, pred_target
  );
  modport slave (
    input  enable, fetch_pc, upd_valid, upd_pc, upd_target, upd_taken, upd_kind, upd_call,
    output pred_taken, pred_target
  );
endinterface

// File: rtl/branch_predictor_ras_return_addr_stack.sv
// Circular return-address stack; overflow silently overwrites the oldest entry.
module return_addr_stack
  import branch_predictor_ras_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_addr,
  output logic [XLEN-1:0] top,
  output logic            empty
);
  localparam int PTR_W = clog2(RAS_DEPTH);

  logic [XLEN-1:0]  stack [RAS_DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_m1;
  logic [PTR_W:0]   count;

  assign ptr_m1 = ptr - PTR_W'(1);
  assign top    = stack[ptr_m1];
  assign empty  = (count == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      count <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) stack[i] <= '0;
    end else if (enable) begin
      // Link-and-return in one instruction swaps the top; on an empty stack it is a plain push.
      if (push && pop && !empty) begin
        stack[ptr_m1] <= push_addr;
      end else if (push) begin
        stack[ptr] <= push_addr;
        ptr        <= ptr + PTR_W'(1);
        if (count != (PTR_W+1)'(RAS_DEPTH)) count <= count + (PTR_W+1)'(1);
      end else if (pop && !empty) begin
        ptr   <= ptr_m1;
        count <= count - (PTR_W+1)'(1);
      end
    end
  end

endmodule

// File: rtl/branch_predictor_ras.sv
// Direct-mapped BTB with 2-bit direction counters and a RAS; combinational lookup,
// non-speculative update from ID-stage resolution.
module branch_predictor_ras
  import branch_predictor_ras_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ENTRIES   = 16,
  parameter int CTR_W     = 2,
  parameter int RAS_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  branch_predictor_ras_if.slave bus
);
  localparam int IDX_W = clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;
  localparam logic [CTR_W-1:0] CTR_RST = CTR_W'(CTR_RESET);
  localparam logic [CTR_W-1:0] CTR_WT  = {1'b1, {(CTR_W-1){1'b0}}};

  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tag_q  [ENTRIES];
  logic [1:0]         kind_q [ENTRIES];
  logic [CTR_W-1:0]   ctr_q  [ENTRIES];
  logic [XLEN-1:0]    tgt_q  [ENTRIES];

  logic [IDX_W-1:0] f_idx, u_idx;
  logic [TAG_W-1:0] f_tag, u_tag;
  logic             f_hit, u_hit, f_taken, upd;
  logic [XLEN-1:0]  ras_top;
  logic             ras_empty;
  logic             unused_pc_lsb;

  assign f_idx = bus.fetch_pc[IDX_W+1:2];
  assign f_tag = bus.fetch_pc[XLEN-1:IDX_W+2];
  assign u_idx = bus.upd_pc[IDX_W+1:2];
  assign u_tag = bus.upd_pc[XLEN-1:IDX_W+2];
  assign f_hit = valid[f_idx] && (tag_q[f_idx] == f_tag);
  assign u_hit = valid[u_idx] && (tag_q[u_idx] == u_tag);
  assign upd   = bus.upd_valid && bus.enable;
  assign unused_pc_lsb = ^bus.fetch_pc[1:0];

  always_comb begin
    f_taken = 1'b0;
    if (f_hit) begin
      if (kind_q[f_idx] == KIND_COND)      f_taken = ctr_q[f_idx][CTR_W-1];
      else if (kind_q[f_idx] == KIND_JUMP) f_taken = 1'b1;
      else if (kind_q[f_idx] == KIND_RET)  f_taken = !ras_empty;
    end
    bus.pred_taken  = f_taken;
    bus.pred_target = '0;
    if (f_taken) bus.pred_target = (kind_q[f_idx] == KIND_RET) ? ras_top : tgt_q[f_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]  <= '0;
        kind_q[i] <= '0;
        ctr_q[i]  <= CTR_RST;
        tgt_q[i]  <= '0;
      end
    end else if (upd) begin
      if (u_hit) begin
        tag_q[u_idx]  <= u_tag;
        kind_q[u_idx] <= bus.upd_kind;
        if (bus.upd_kind == KIND_COND) begin
          // Not-taken outcomes keep the last taken target.
          if (bus.upd_taken) begin
            tgt_q[u_idx] <= bus.upd_target;
            if (ctr_q[u_idx] != '1) ctr_q[u_idx] <= ctr_q[u_idx] + CTR_W'(1);
          end else if (ctr_q[u_idx] != '0) begin
            ctr_q[u_idx] <= ctr_q[u_idx] - CTR_W'(1);
          end
        end else begin
          tgt_q[u_idx] <= bus.upd_target;
        end
      end else if (bus.upd_taken) begin
        valid[u_idx]  <= 1'b1;
        tag_q[u_idx]  <= u_tag;
        kind_q[u_idx] <= bus.upd_kind;
        ctr_q[u_idx]  <= CTR_WT;
        tgt_q[u_idx]  <= bus.upd_target;
      end
    end
  end

  return_addr_stack #(.XLEN(XLEN), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clk       (clk),
    .rst       (rst),
    .enable    (bus.enable),
    .push      (bus.upd_valid && bus.upd_call),
    .pop       (bus.upd_valid && (bus.upd_kind == KIND_RET)),
    .push_addr (bus.upd_pc + XLEN'(4)),
    .top       (ras_top),
    .empty     (ras_empty)
  );

endmodule
